// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide main-memory port between the
// I-cache refill path and the D-cache refill/write-back path, with a watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [1:0]         gnt;
  logic               last_is_d;
  logic               seen_busy;
  logic [CNT_W-1:0]   wd_cnt;
  logic [DATA_W-1:0]  rd_buf;

  logic i_req, d_req, complete, wd_expire;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Memory must have been seen busy at least once before a low busywait counts as done.
  assign complete  = (state == ACCESS) && seen_busy && !mem_busywait;
  assign wd_expire = (state == ACCESS) && !complete && (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      gnt         <= GNT_NONE;
      last_is_d   <= 1'b0;
      seen_busy   <= 1'b0;
      wd_cnt      <= '0;
      rd_buf      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            gnt   <= last_is_d ? GNT_I : GNT_D;
            state <= ACCESS;
          end else if (i_req) begin
            gnt   <= GNT_I;
            state <= ACCESS;
          end else if (d_req) begin
            gnt   <= GNT_D;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (mem_busywait) seen_busy <= 1'b1;
          if (complete) begin
            rd_buf    <= mem_readdata;
            last_is_d <= (gnt == GNT_D);
            state     <= DONE;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            rd_buf      <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          seen_busy <= 1'b0;
          wd_cnt    <= '0;
          gnt       <= GNT_NONE;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes track the granted requester's live inputs during ACCESS only.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    if (state == ACCESS) begin
      if (gnt == GNT_I) begin
        mem_read    = i_read;
        mem_address = i_address;
      end else if (gnt == GNT_D) begin
        mem_address   = d_address;
        mem_writedata = d_writedata;
        if (d_write) mem_write = 1'b1;
        else         mem_read  = d_read;
      end
    end
  end

  assign i_busywait = i_req & !((state == DONE) && (gnt == GNT_I));
  assign d_busywait = d_req & !((state == DONE) && (gnt == GNT_D));
  assign i_readdata = rd_buf;
  assign d_readdata = rd_buf;
  assign grant      = gnt;

endmodule
